ir_cmd_decoder: RTL
===================

Name: ir_cmd_decoder

Overview:
- Sits between the IR receiver and the game/state logic. Consumes the latched 32-bit NEC word, which changes asynchronously in the receiver's clock domain.
- Filters the word for stability and validates its framing. Emits one-cycle command strobes and maintains the snake heading with reversal rejection.
- Replaces the raw word comparisons in the top level with clean, single-cycle events.

Parameters:
- STABLE_CYCLES, 1024, consecutive clock cycles the word must stay unchanged before it is accepted (2..65535).
- ADDR, 8'h20, expected NEC address byte.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- word  in  32  latched NEC frame from the IR receiver: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- game_active  in  1  high while the game screen runs; enables reversal rejection.
- cmd  out  4  decoded command: 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 ENTER, 6 MENU, 7 DIGIT.
- cmd_valid  out  1  one-cycle strobe qualifying cmd and level.
- level  out  3  digit value 1..6 when cmd=DIGIT; 0 otherwise.
- dir  out  2  current heading: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- dir_valid  out  1  one-cycle strobe when dir changes.
- err_count  out  8  saturating count of rejected frames.

Behaviour:
- Reset values (asynchronous):
  - cmd=0, cmd_valid=0, level=0, dir=3 (RIGHT), dir_valid=0, err_count=0.
  - Internal word_q=0, last_acc=0, stable counter=0, FSM=WAIT.
- word_q registers word every cycle. The counter clears when word_q != previous word_q, and otherwise increments, saturating at STABLE_CYCLES-1.
- FSM WAIT:
  - Stays in WAIT while the counter is below STABLE_CYCLES-1.
  - At STABLE_CYCLES-1, goes to DECODE if word_q != last_acc and word_q != 0.
  - Otherwise stays in WAIT. The same key is therefore never re-emitted while word is unchanged.
- FSM DECODE (1 cycle):
  - Latch last_acc <= word_q.
  - Match the cmd byte: 6A UP, EA DOWN, 1A LEFT, 9A RIGHT, 5A ENTER, C2 MENU; 88/48/C8/28/A8/68 are DIGIT with level 1..6.
  - Goes to EMIT.
- FSM EMIT (1 cycle), then back to WAIT:
  - Valid known frame: pulse cmd_valid with cmd/level.
  - Invalid or unknown frame: no cmd_valid; err_count increments, saturating at 255.
  - cmd and level hold their values until the next emit.
- Latency: cmd_valid is high exactly STABLE_CYCLES+2 cycles after the first cycle word_q shows the new value.
- Heading update, evaluated on a cmd_valid with a direction cmd:
  - game_active=1 and the new direction is opposite the current dir (UP/DOWN, LEFT/RIGHT): dir is unchanged and there is no dir_valid. The cmd_valid strobe still fires.
  - Same direction as current: no change, no dir_valid.
  - Otherwise: dir updates the same cycle as cmd_valid, and dir_valid pulses in that cycle.
- game_active=0:
  - Reversals are allowed.
  - On the falling edge of game_active, dir forces to RIGHT with no dir_valid.
- Word changing during DECODE/EMIT: the FSM finishes its current pass. The new word is filtered from the cycle it appears, because the counter runs independently.
- Reset mid-operation: all state clears immediately. A word already present at release is re-accepted after STABLE_CYCLES.

Optional Feature:
- IR_CHECKSUM_EN defined:
  - A frame is valid only if addr==ADDR, [23:16]==~addr, and [7:0]==~[15:8].
  - A checksum failure counts as an error.
- IR_CHECKSUM_EN undefined:
  - Only the cmd byte is compared.
  - Bits [31:16] and [7:0] are ignored, so this saves comparators.
  - Only unknown cmd bytes count as errors.

Test Plan:
- Reset, STABLE_CYCLES=16, word=32'h20DF6A95 held → cmd_valid=1 with cmd=1 (UP) at cycle 18 after word_q updates; dir=0, dir_valid=1 in the same cycle; exactly one strobe over the next 1000 cycles.
- game_active=1, dir=RIGHT, apply LEFT 32'h20DF1AE5 → cmd_valid with cmd=3; dir stays 3; no dir_valid. Then apply UP → dir=0, dir_valid=1.
- word toggles every 8 cycles between two codes for 200 cycles, then settles on 32'h20DFA857 → no strobe while toggling; then exactly one cmd=7, level=5.
- IR_CHECKSUM_EN defined, word=32'h20DF6A94 (bad ~cmd) → no cmd_valid, err_count=1. Feed 300 distinct bad frames → err_count saturates at 255.
- Assert reset_n low for 1 cycle during a stability count, with ENTER 32'h20DF5AA5 held → all outputs return to reset values; after release one cmd=5 strobe occurs STABLE_CYCLES+2 cycles later.
- game_active 1→0 with dir=UP → dir=RIGHT the next cycle, no dir_valid. With game_active=0, DOWN then UP both update dir, each with dir_valid.

Source files
------------

// File: rtl/ir_cmd_decoder.sv
// ir_cmd_decoder: stability-filtered NEC word decoder with one-cycle command strobes and snake heading.
// Define IR_CHECKSUM_EN to also require the address byte and both complement bytes.
module ir_cmd_decoder #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter logic [7:0]  ADDR          = 8'h20
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [31:0] word,
    input  logic        game_active,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    output logic [2:0]  level,
    output logic [1:0]  dir,
    output logic        dir_valid,
    output logic [7:0]  err_count
);
    typedef enum logic [1:0] {WAIT, DECODE, EMIT} state_t;
`ifdef IR_CHECKSUM_EN
    localparam logic CHECKSUM = 1'b1;
`else
    localparam logic CHECKSUM = 1'b0;
`endif
    localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);
    state_t      state, state_nx;
    logic [31:0] word_q, word_p, last_acc;
    logic [15:0] cnt;
    logic        ga_q, accept, frame_ok, good, is_dir, turn;
    logic [3:0]  dec_cmd;
    logic [2:0]  dec_lvl;
    logic [1:0]  new_dir;
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            word_q <= '0;
            word_p <= '0;
            cnt    <= '0;
        end else begin
            word_q <= word;
            word_p <= word_q;
            cnt    <= (word_q != word_p) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
        end
    // word_q == word_p keeps a saturated count from a previous word from accepting a fresh one
    assign accept = cnt == CNT_MAX && word_q == word_p && word_q != last_acc && word_q != '0;
    always_comb
        state_nx = state == WAIT ? (accept ? DECODE : WAIT) : state == DECODE ? EMIT : WAIT;
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) state <= WAIT;
        else state <= state_nx;
    always_comb begin
        dec_cmd = 4'd0;
        dec_lvl = 3'd0;
        case (word_q[15:8])
            8'h6A: dec_cmd = 4'd1;
            8'hEA: dec_cmd = 4'd2;
            8'h1A: dec_cmd = 4'd3;
            8'h9A: dec_cmd = 4'd4;
            8'h5A: dec_cmd = 4'd5;
            8'hC2: dec_cmd = 4'd6;
            8'h88: begin dec_cmd = 4'd7; dec_lvl = 3'd1; end
            8'h48: begin dec_cmd = 4'd7; dec_lvl = 3'd2; end
            8'hC8: begin dec_cmd = 4'd7; dec_lvl = 3'd3; end
            8'h28: begin dec_cmd = 4'd7; dec_lvl = 3'd4; end
            8'hA8: begin dec_cmd = 4'd7; dec_lvl = 3'd5; end
            8'h68: begin dec_cmd = 4'd7; dec_lvl = 3'd6; end
            default: ;
        endcase
    end
    assign frame_ok = !CHECKSUM || (word_q[31:24] == ADDR && word_q[23:16] == ~word_q[31:24]
                                    && word_q[7:0] == ~word_q[15:8]);
    assign good     = dec_cmd != 4'd0 && frame_ok;
    assign is_dir   = dec_cmd != 4'd0 && dec_cmd <= 4'd4;
    assign new_dir  = 2'(dec_cmd - 4'd1);
    // headings pair up as UP/DOWN and LEFT/RIGHT, so the reverse differs only in bit 0
    assign turn     = state == DECODE && good && is_dir && new_dir != dir
                      && !(game_active && new_dir == (dir ^ 2'd1));
    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            cmd       <= 4'd0;
            cmd_valid <= 1'b0;
            level     <= 3'd0;
            dir       <= 2'd3;
            dir_valid <= 1'b0;
            err_count <= 8'd0;
            last_acc  <= '0;
            ga_q      <= 1'b0;
        end else begin
            ga_q      <= game_active;
            cmd_valid <= 1'b0;
            dir_valid <= 1'b0;
            if (state == DECODE) begin
                last_acc <= word_q;
                if (good) begin
                    cmd       <= dec_cmd;
                    level     <= dec_lvl;
                    cmd_valid <= 1'b1;
                end else if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
            if (ga_q && !game_active) begin
                dir <= 2'd3;
            end else if (turn) begin
                dir       <= new_dir;
                dir_valid <= 1'b1;
            end
        end
endmodule
